conv_loop_scheduler: RTL
========================

Name: conv_loop_scheduler

Overview:
Top-level sequencer for one convolution layer on the MAC_ROW x MAC_COL systolic array. It walks the loop nest: output-channel tile, then kernel row, kernel column, and input-channel tile. For each step it runs three phases in order: weight preload, ifmap streaming, and array drain. It also drives the tile and kernel indices and the accumulate-control flags consumed by the weight, ifmap and ofmap address controllers.

Parameters:
MAC_ROW, 16, array rows (input channels per tile)
MAC_COL, 16, array columns (output channels per tile)
OFMAP_CHANNEL_NUM, 64, output channels; must be a multiple of MAC_COL
IFMAP_CHANNEL_NUM, 32, input channels; must be a multiple of MAC_ROW
WEIGHT_WIDTH, 3, kernel width
WEIGHT_HEIGHT, 3, kernel height
OFMAP_WIDTH, 14, output width
OFMAP_HEIGHT, 14, output height

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start_in  in  1  layer start; sampled only in IDLE
stall_in  in  1  freeze all state and counters while high
busy_out  out  1  high in every state except IDLE and DONE
done_out  out  1  one-cycle pulse when the layer completes
w_load_en_out  out  1  weight preload enable, one array column per cycle
ifmap_stream_en_out  out  1  ifmap pixel issue enable
drain_out  out  1  array drain phase
o_ch_tile_out  out  32  current output-channel tile, 0..OCT-1
i_ch_tile_out  out  32  current input-channel tile, 0..ICT-1
w_w_out  out  32  kernel column index
w_h_out  out  32  kernel row index
phase_count_out  out  32  cycle index within the current phase
acc_first_out  out  1  STREAM of the first step of an o_ch tile; ofmap overwrites instead of accumulating
acc_last_out  out  1  STREAM of the last step of an o_ch tile; psum is final

Behaviour:
- Derived constants: OCT = OFMAP_CHANNEL_NUM/MAC_COL; ICT = IFMAP_CHANNEL_NUM/MAC_ROW; NPIX = OFMAP_WIDTH*OFMAP_HEIGHT; NDRAIN = MAC_ROW+MAC_COL-1.
- Parameter checks: elaboration fails (assertion) if either channel count is not a multiple of its array dimension.
- Reset: synchronous on rstn=0. State IDLE; all counters 0; all 1-bit outputs 0. Reset mid-layer aborts immediately, with no done_out.
- States: IDLE, WLOAD, STREAM, DRAIN, NEXT, DONE.
- IDLE: when start_in=1 at clock edge k, state is WLOAD from cycle k+1 and phase_count is cleared to 0.
- WLOAD: lasts MAC_COL cycles; w_load_en_out=1; phase_count runs 0..MAC_COL-1; then goes to STREAM.
- STREAM: lasts NPIX cycles; ifmap_stream_en_out=1; phase_count runs 0..NPIX-1; then goes to DRAIN.
- DRAIN: lasts NDRAIN cycles; drain_out=1; then goes to NEXT.
- NEXT: one cycle; advances the loop counters.
  - Loop order, innermost first: i_ch_tile, w_w, w_h, o_ch_tile.
  - Each counter wraps to 0 and carries into the next outer counter.
  - If all four counters were at their maxima, go to DONE; otherwise go to WLOAD.
- DONE: one cycle; done_out=1; busy_out=0; counters reset to 0; then goes to IDLE.
- Cycle budget: each step takes STEP = MAC_COL+NPIX+NDRAIN+1 cycles. With no stalls, done_out is asserted exactly OCT*ICT*WEIGHT_WIDTH*WEIGHT_HEIGHT*STEP+1 cycles after the start edge.
- Output timing: all outputs are registered or decoded from registered state and counters, with no combinational path from any input. Indices are held stable for the whole step and change only on leaving NEXT.
- acc_first_out = STREAM & i_ch_tile==0 & w_w==0 & w_h==0.
- acc_last_out = STREAM & i_ch_tile==ICT-1 & w_w==WEIGHT_WIDTH-1 & w_h==WEIGHT_HEIGHT-1.
- Both acc flags are high together when ICT=WEIGHT_WIDTH=WEIGHT_HEIGHT=1.
- stall_in=1 (any non-IDLE state):
  - state, counters and phase_count hold;
  - w_load_en_out, ifmap_stream_en_out and drain_out are forced to 0;
  - index outputs hold.
- stall_in in IDLE: has no effect, and start is still accepted.
- Stall in DONE: done_out stays high until the stall is released, so the pulse is still exactly one unstalled cycle.
- start_in while busy: ignored. start_in in the DONE cycle: ignored. A new layer needs start_in high in IDLE.
- Counter width: all counters are 32-bit unsigned; no overflow is possible within legal parameters.

Test Plan:
1. Small config (MAC 2x2, O_CH=4, I_CH=4, kernel 2x2, ofmap 2x2; STEP=10), start pulse at cycle 0 -> done_out at cycle 161; busy_out high for cycles 1..160; exactly 16 WLOAD phases.
2. Same config -> index sequence (o,h,w,i) is (0,0,0,0),(0,0,0,1),(0,0,1,0)...(1,1,1,1). acc_first_out high for 4 STREAM cycles at steps 0 and 8; acc_last_out at steps 7 and 15.
3. Default params -> w_load_en_out high for 16 cycles, then ifmap_stream_en_out high for 196 cycles, drain_out for 31 cycles; total cycles = 72*244+1 = 17569.
4. Small config, stall_in high for 5 cycles in mid-STREAM -> enables drop to 0; phase_count and indices hold; done_out delayed by exactly 5 cycles, to cycle 166.
5. Small config, rstn low at cycle 50 -> next cycle all outputs 0 in IDLE; no done_out; restart at cycle 60 completes at cycle 221.
6. start_in held continuously high -> layers run back-to-back. Each done_out is followed by one IDLE cycle, then WLOAD; extra starts during busy have no effect.

Source files
------------

// File: rtl/conv_loop_scheduler.sv
// Loop-nest sequencer for one convolution layer on the systolic array.
// Each (o_ch tile, kernel row, kernel col, i_ch tile) step runs weight preload, ifmap stream, drain, next.
module conv_loop_scheduler #(
  parameter int MAC_ROW           = 16,
  parameter int MAC_COL           = 16,
  parameter int OFMAP_CHANNEL_NUM = 64,
  parameter int IFMAP_CHANNEL_NUM = 32,
  parameter int WEIGHT_WIDTH      = 3,
  parameter int WEIGHT_HEIGHT     = 3,
  parameter int OFMAP_WIDTH       = 14,
  parameter int OFMAP_HEIGHT      = 14
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_in,
  input  logic        stall_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        w_load_en_out,
  output logic        ifmap_stream_en_out,
  output logic        drain_out,
  output logic [31:0] o_ch_tile_out,
  output logic [31:0] i_ch_tile_out,
  output logic [31:0] w_w_out,
  output logic [31:0] w_h_out,
  output logic [31:0] phase_count_out,
  output logic        acc_first_out,
  output logic        acc_last_out
);

  localparam logic [31:0] OCT    = 32'(OFMAP_CHANNEL_NUM / MAC_COL);
  localparam logic [31:0] ICT    = 32'(IFMAP_CHANNEL_NUM / MAC_ROW);
  localparam logic [31:0] KW     = 32'(WEIGHT_WIDTH);
  localparam logic [31:0] KH     = 32'(WEIGHT_HEIGHT);
  localparam logic [31:0] NWLOAD = 32'(MAC_COL);
  localparam logic [31:0] NPIX   = 32'(OFMAP_WIDTH * OFMAP_HEIGHT);
  localparam logic [31:0] NDRAIN = 32'(MAC_ROW + MAC_COL - 1);

  if ((OFMAP_CHANNEL_NUM % MAC_COL) != 0) begin : g_bad_och
    $error("OFMAP_CHANNEL_NUM must be a multiple of MAC_COL");
  end
  if ((IFMAP_CHANNEL_NUM % MAC_ROW) != 0) begin : g_bad_ich
    $error("IFMAP_CHANNEL_NUM must be a multiple of MAC_ROW");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_STREAM,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_o;
  logic [31:0] r_i;
  logic [31:0] r_w;
  logic [31:0] r_h;
  logic [31:0] r_phase;
  logic        r_stall;

  logic w_hold;
  logic w_phase_end;
  logic w_i_last;
  logic w_w_last;
  logic w_h_last;
  logic w_o_last;

  // IDLE ignores stall so a start is never lost
  assign w_hold   = stall_in && (r_state != S_IDLE);
  assign w_i_last = (r_i == ICT - 32'd1);
  assign w_w_last = (r_w == KW - 32'd1);
  assign w_h_last = (r_h == KH - 32'd1);
  assign w_o_last = (r_o == OCT - 32'd1);

  always_comb begin
    w_phase_end = 1'b0;
    case (r_state)
      S_WLOAD:  w_phase_end = (r_phase == NWLOAD - 32'd1);
      S_STREAM: w_phase_end = (r_phase == NPIX - 32'd1);
      S_DRAIN:  w_phase_end = (r_phase == NDRAIN - 32'd1);
      default:  w_phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_o     <= '0;
      r_i     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_phase <= '0;
      r_stall <= 1'b0;
    end else begin
      r_stall <= w_hold;
      if (!w_hold) begin
        case (r_state)
          S_IDLE: begin
            if (start_in) begin
              r_state <= S_WLOAD;
              r_phase <= '0;
            end
          end
          S_WLOAD: begin
            if (w_phase_end) begin
              r_state <= S_STREAM;
              r_phase <= '0;
            end else begin
              r_phase <= r_phase + 32'd1;
            end
          end
          S_STREAM: begin
            if (w_phase_end) begin
              r_state <= S_DRAIN;
              r_phase <= '0;
            end else begin
              r_phase <= r_phase + 32'd1;
            end
          end
          S_DRAIN: begin
            if (w_phase_end) begin
              r_state <= S_NEXT;
              r_phase <= '0;
            end else begin
              r_phase <= r_phase + 32'd1;
            end
          end
          S_NEXT: begin
            r_phase <= '0;
            if (w_i_last && w_w_last && w_h_last && w_o_last) begin
              r_state <= S_DONE;
              r_o     <= '0;
              r_i     <= '0;
              r_w     <= '0;
              r_h     <= '0;
            end else begin
              // innermost first: i_ch tile, kernel col, kernel row, o_ch tile
              r_state <= S_WLOAD;
              r_i     <= w_i_last ? '0 : r_i + 32'd1;
              if (w_i_last) begin
                r_w <= w_w_last ? '0 : r_w + 32'd1;
                if (w_w_last) begin
                  r_h <= w_h_last ? '0 : r_h + 32'd1;
                  if (w_h_last) begin
                    r_o <= r_o + 32'd1;
                  end
                end
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_o     <= '0;
            r_i     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_phase <= '0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // r_stall gates the enables in the frozen cycles without an input-to-output path
  assign busy_out            = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done_out            = (r_state == S_DONE);
  assign w_load_en_out       = (r_state == S_WLOAD)  && !r_stall;
  assign ifmap_stream_en_out = (r_state == S_STREAM) && !r_stall;
  assign drain_out           = (r_state == S_DRAIN)  && !r_stall;
  assign o_ch_tile_out       = r_o;
  assign i_ch_tile_out       = r_i;
  assign w_w_out             = r_w;
  assign w_h_out             = r_h;
  assign phase_count_out     = r_phase;
  assign acc_first_out       = (r_state == S_STREAM) && (r_i == '0) && (r_w == '0) && (r_h == '0);
  assign acc_last_out        = (r_state == S_STREAM) && w_i_last && w_w_last && w_h_last;

endmodule
